uart_ddr_byte_packer: RTL and testbench

Packs the 8-bit byte stream from the UART receiver into DATA_WIDTH-bit words and writes them into the write side of the DDR staging FIFO. The DDR AXI write master drains that FIFO in bursts. The block uses a two-register scheme: an assembly register and a holding register. This lets reception continue while a completed word waits on FIFO backpressure. Partial words are flushed with pad bytes, either on an idle timeout or on an explicit flush request.

---
 rtl/uart_ddr_byte_packer.sv | 136 +++++++++++++
 tb/tb_uart_ddr_byte_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ddr_byte_packer.sv
// Packs UART bytes little-endian into DATA_WIDTH-bit words for the DDR staging FIFO.
// An assembly register fills while a holding register waits out FIFO backpressure.
module uart_ddr_byte_packer #(
  parameter int          DATA_WIDTH     = 256,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic                  i_axi_clk,
  input  logic                  i_rstn,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_flush,
  input  logic                  i_clr_overflow,
  input  logic                  i_fifo_full,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic                  o_fifo_wr_en,
  output logic                  o_overflow,
  output logic [15:0]           o_drop_count,
  output logic [31:0]           o_word_count,
  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FILLING  = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d, hold_q;
  logic                  hold_valid_q;
  logic [31:0]           idle_q, idle_d;
  logic                  transfer, accept, drop, timeout, pad_en, last_slot;
  int                    fill_end;

  // FIFO handshake: a word is written in every cycle o_fifo_wr_en is high; the
  // FIFO must take it whenever it reports not full, so wr_en never waits on an ack.
  assign o_fifo_wr_en = hold_valid_q & ~i_fifo_full;
  assign o_fifo_data  = hold_q;
  assign o_busy       = (state_q != S_EMPTY) | hold_valid_q;
  assign o_dbg_state  = state_q;

  always_comb begin
    transfer  = (state_q == S_COMPLETE) & (~hold_valid_q | o_fifo_wr_en);
    accept    = i_rx_valid & ((state_q != S_COMPLETE) | transfer);
    drop      = i_rx_valid & (state_q == S_COMPLETE) & ~transfer;
    last_slot = (idx_q == IDX_W'(BYTES - 1));
    timeout   = (TIMEOUT_CYCLES != 0) && (state_q == S_FILLING) && !i_rx_valid &&
                (idle_q + 32'd1 == 32'(TIMEOUT_CYCLES));
    pad_en    = (state_q == S_FILLING) & (i_flush | timeout);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_EMPTY, S_FILLING: begin
        if (accept && last_slot) begin
          state_d = S_COMPLETE;
          idx_d   = '0;
        end else if (pad_en) begin
          state_d = S_COMPLETE;
          idx_d   = '0;
        end else if (accept) begin
          state_d = S_FILLING;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_COMPLETE: begin
        if (transfer) begin
          state_d = i_rx_valid ? S_FILLING : S_EMPTY;
          idx_d   = i_rx_valid ? IDX_W'(1) : '0;
        end
      end
      default: begin
        state_d = S_EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  // Incoming byte lands at idx_q; on a flush every slot past it takes PAD_BYTE.
  always_comb begin
    asm_d    = asm_q;
    fill_end = int'(idx_q) + (accept ? 1 : 0);
    for (int k = 0; k < BYTES; k++) begin
      if (accept && int'(idx_q) == k) begin
        asm_d[8*k +: 8] = i_rx_data;
      end else if (pad_en && k >= fill_end) begin
        asm_d[8*k +: 8] = PAD_BYTE;
      end
    end
    idle_d = (state_q != S_FILLING || accept || timeout) ? 32'd0 : idle_q + 32'd1;
  end

  always_ff @(posedge i_axi_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
      asm_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      idle_q  <= idle_d;
    end
  end

  always_ff @(posedge i_axi_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else begin
      if (transfer) begin
        hold_q       <= asm_q;
        hold_valid_q <= 1'b1;
      end else if (o_fifo_wr_en) begin
        hold_valid_q <= 1'b0;
      end
      if (o_fifo_wr_en) o_word_count <= o_word_count + 32'd1;
      if (drop) o_overflow <= 1'b1;
      else if (i_clr_overflow) o_overflow <= 1'b0;
      if (drop && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_ddr_byte_packer.sv
// Randomized bench for uart_ddr_byte_packer: a queue-based byte/word model predicts
// every FIFO write (data and cycle) and the status counters.
module tb_uart_ddr_byte_packer;
  localparam int         W     = 256;
  localparam int         BYTES = W / 8;
  localparam int         T     = 16;
  localparam logic [7:0] PAD   = 8'h5A;

  logic          clk, rstn;
  logic [7:0]    rx_data;
  logic          rx_valid, flush, clr_ovf, fifo_full;
  logic [W-1:0]  fifo_data;
  logic          wr_en, ovf, busy;
  logic [15:0]   drop_count;
  logic [31:0]   word_count;
  logic [1:0]    dbg_state;

  uart_ddr_byte_packer #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(T), .PAD_BYTE(PAD)) dut (
    .i_axi_clk(clk), .i_rstn(rstn), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_flush(flush), .i_clr_overflow(clr_ovf), .i_fifo_full(fifo_full),
    .o_fifo_data(fifo_data), .o_fifo_wr_en(wr_en), .o_overflow(ovf),
    .o_drop_count(drop_count), .o_word_count(word_count), .o_busy(busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   part_q[$];
  bit           asm_done, hold_full, m_ovf;
  logic [W-1:0] asm_word, hold_word;
  int           idle, m_drops;
  int unsigned  m_words;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  function automatic logic [W-1:0] take_word();
    logic [W-1:0] w;
    for (int i = 0; i < BYTES; i++) w[8*i +: 8] = (i < part_q.size()) ? part_q[i] : PAD;
    part_q.delete();
    return w;
  endfunction

  function automatic void model_reset();
    part_q.delete(); exp_q.delete(); exp_cyc_q.delete();
    asm_done = 0; hold_full = 0; m_ovf = 0; idle = 0; m_drops = 0; m_words = 0;
    asm_word = '0; hold_word = '0;
  endfunction

  function automatic void model_step(bit v, logic [7:0] b, bit fl, bit full, bit clr);
    bit wr, xfer, drp, had;
    wr = hold_full && !full;
    if (wr) begin
      exp_q.push_back(hold_word);
      exp_cyc_q.push_back(cyc);
      m_words++;
    end
    xfer = asm_done && (!hold_full || wr);
    drp  = 0;
    if (xfer) begin hold_word = asm_word; hold_full = 1; end
    else if (wr) hold_full = 0;
    if (asm_done) begin
      if (xfer) begin asm_done = 0; if (v) part_q.push_back(b); end
      else if (v) drp = 1;
      idle = 0;
    end else begin
      had = part_q.size() > 0;
      if (v) part_q.push_back(b);
      if (part_q.size() == BYTES) begin asm_word = take_word(); asm_done = 1; end
      else if (had && fl) begin asm_word = take_word(); asm_done = 1; end
      else if (had && !v) begin
        idle++;
        if (idle == T) begin asm_word = take_word(); asm_done = 1; end
      end
      if (v || asm_done) idle = 0;
    end
    if (drp) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end else if (clr) m_ovf = 0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [7:0] b, input bit fl, input bit full, input bit clr);
    @(posedge clk); #1;
    cyc++;
    check("overflow", ovf, m_ovf);
    check("drop_count", drop_count, m_drops[15:0]);
    check("word_count", word_count, m_words);
    check("busy", busy, asm_done || part_q.size() > 0 || hold_full);
    rx_valid = v; rx_data = b; flush = fl; fifo_full = full; clr_ovf = clr;
    model_step(v, b, fl, full, clr);
  endtask

  task automatic idle_cycles(input int n, input bit full);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, full, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 0; rx_valid = 0; rx_data = 0; flush = 0; clr_ovf = 0; fifo_full = 0;
    model_reset();
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_overflow", ovf, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_word_count", word_count, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] last_wr_data;
  int           last_wr_cyc = -1;
  int           prev_wr_cyc = -1;

  always @(negedge clk) begin
    if (rstn) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        check("missing_write", 0, 1);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (wr_en) begin
        prev_wr_cyc  = last_wr_cyc;
        last_wr_cyc  = cyc;
        last_wr_data = fifo_data;
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          check("write_cycle", cyc, exp_cyc_q.pop_front());
          check("write_data", fifo_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] lit;
  int           t_ref;
  int unsigned  wc0;
  bit           rfull;

  initial begin
    rstn = 1; rx_valid = 0; rx_data = 0; flush = 0; clr_ovf = 0; fifo_full = 0;
    model_reset();
    #2;
    do_reset();

    // Full word, one byte every 4 cycles.
    for (int i = 0; i < BYTES; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      t_ref = cyc;
      idle_cycles(3, 0);
    end
    idle_cycles(4, 0);
    lit = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    check("first_word_data", last_wr_data, lit);
    check("first_word_latency", last_wr_cyc - t_ref, 2);
    check("first_word_count", word_count, 1);
    check("first_idle_busy", busy, 0);

    // Partial word flushed by idle timeout.
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'hA1 + i), 0, 0, 0);
      t_ref = cyc;
    end
    idle_cycles(T + 6, 0);
    lit = {{(BYTES - 5){PAD}}, 40'hA5A4A3A2A1};
    check("timeout_data", last_wr_data, lit);
    check("timeout_latency", last_wr_cyc - t_ref, T + 2);

    // Partial word flushed by explicit pulse.
    for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 0, 0, 0);
    drive(0, 8'h00, 1, 0, 0);
    t_ref = cyc;
    idle_cycles(5, 0);
    check("flush_latency", last_wr_cyc - t_ref, 2);

    // FIFO held full across 65 bytes, then released.
    wc0 = word_count;
    for (int i = 0; i < 2 * BYTES + 1; i++) begin
      drive(1, 8'($urandom), 0, 1, 0);
      drive(0, 8'h00, 0, 1, 0);
    end
    check("bp_overflow", ovf, 1);
    check("bp_drop_count", drop_count, 1);
    idle_cycles(5, 0);
    check("bp_consecutive", last_wr_cyc - prev_wr_cyc, 1);
    check("bp_word_delta", word_count - wc0, 2);

    // Clearing overflow, alone and against a simultaneous drop.
    drive(0, 8'h00, 0, 0, 1);
    idle_cycles(1, 0);
    check("clr_overflow", ovf, 0);
    check("clr_keeps_drops", drop_count, 1);
    for (int i = 0; i < 2 * BYTES; i++) drive(1, 8'($urandom), 0, 1, 0);
    drive(1, 8'h77, 0, 1, 1);
    idle_cycles(1, 1);
    check("clr_vs_drop", ovf, 1);
    check("clr_vs_drop_count", drop_count, 2);
    idle_cycles(5, 0);

    // Reset in the middle of a word.
    for (int i = 0; i < 10; i++) drive(1, 8'($urandom), 0, 0, 0);
    do_reset();
    for (int i = 0; i < BYTES; i++) drive(1, 8'(8'hC0 + i), 0, 0, 0);
    idle_cycles(4, 0);
    for (int i = 0; i < BYTES; i++) lit[8*i +: 8] = 8'(8'hC0 + i);
    check("post_reset_word", last_wr_data, lit);
    check("post_reset_count", word_count, 1);

    // Flush in EMPTY is ignored; flush with the 32nd byte is an ordinary completion.
    drive(0, 8'h00, 1, 0, 0);
    idle_cycles(4, 0);
    check("flush_empty_no_write", word_count, 1);
    for (int i = 0; i < BYTES - 1; i++) drive(1, 8'(8'h10 + i), 0, 0, 0);
    drive(1, 8'hEF, 1, 0, 0);
    idle_cycles(4, 0);
    for (int i = 0; i < BYTES - 1; i++) lit[8*i +: 8] = 8'(8'h10 + i);
    lit[W-1 -: 8] = 8'hEF;
    check("flush_last_byte_word", last_wr_data, lit);
    check("flush_last_byte_count", word_count, 2);

    // Random traffic with bursty backpressure, flushes and clears.
    rfull = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) rfull = ~rfull;
      drive($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 59) == 0,
            rfull, $urandom_range(0, 99) == 0);
    end
    idle_cycles(T + 2 * BYTES, 0);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
